syn_bus_packer: RTL and testbench
=================================

Name: syn_bus_packer

Overview:
- Downstream consumer of the multi-bit bus synchronizer, in the destination clock domain.
- Captures each synchronized BUS_WIDTH chunk, qualified by the synchronizer's single-cycle enable pulse.
- Packs NUM_CHUNKS consecutive chunks into one wide word.
- Presents the word on a valid/ready output with one completed word of buffering; dropped chunks raise a sticky overflow flag.

Parameters:
- BUS_WIDTH, 2, width of each synchronized chunk; must equal the synchronizer's bus width.
- NUM_CHUNKS, 4, chunks per packed word; legal range 2..16.
- OUT_WIDTH, BUS_WIDTH*NUM_CHUNKS, packed word width; derived, must not be overridden.

Ports:
- CLK  input  1  destination-domain clock; all logic on rising edge.
- RST  input  1  asynchronous, active-high reset.
- sync_bus  input  BUS_WIDTH  synchronized chunk from the bus synchronizer.
- enable_pulse  input  1  single-cycle strobe; sync_bus is valid in this cycle.
- flush  input  1  synchronous; discards a partially assembled word.
- out_ready  input  1  consumer accepts out_data when high together with out_valid.
- out_data  output  OUT_WIDTH  packed word; registered.
- out_valid  output  1  out_data holds an unconsumed word.
- overflow  output  1  sticky; set when a chunk is dropped.
- chunk_cnt  output  $clog2(NUM_CHUNKS)+1  chunks currently in the assembly buffer.

Behaviour:
- Reset (async assert; release synchronous to CLK): out_data=0, out_valid=0, overflow=0, chunk_cnt=0, assembly buffer=0, state=FILL.
- Packing order (default): first chunk goes to bits [BUS_WIDTH-1:0]; chunk k goes to bits [k*BUS_WIDTH +: BUS_WIDTH].
- State FILL, on each edge with enable_pulse=1:
  - write chunk at index chunk_cnt and increment chunk_cnt.
  - On the last chunk (chunk_cnt==NUM_CHUNKS-1), if the output slot is free or is being drained this edge (out_valid & out_ready): move the word to out_data, set out_valid, clear chunk_cnt. out_valid is high on the same edge that samples the last chunk (0-cycle latency after the capture edge).
  - Otherwise, keep the word in the assembly buffer, set chunk_cnt=NUM_CHUNKS, go to HOLD.
- State HOLD:
  - On an edge with out_valid & out_ready: load the held word into out_data, keep out_valid=1, clear chunk_cnt, go to FILL. No bubble.
  - enable_pulse in HOLD: chunk dropped, overflow<=1, assembly buffer unchanged.
- Output handshake:
  - out_data is stable while out_valid=1 and out_ready=0.
  - out_valid falls after acceptance only if no new word is loaded on that edge.
- flush:
  - In FILL: clear chunk_cnt and the assembly buffer. An enable_pulse in the same cycle is discarded and does not set overflow.
  - In HOLD: no effect.
  - Never affects out_data, out_valid or overflow.
- overflow: cleared only by RST.
- Simultaneous last-chunk completion and output acceptance: the new word replaces the accepted one on that edge; out_valid stays 1.
- Reset mid-word: the partial word is lost and no output is produced.

Optional Feature:
- Macro SYN_PACKER_MSB_FIRST_EN.
- Defined: the first chunk is placed at the top, bits [OUT_WIDTH-1 -: BUS_WIDTH]; chunk k goes to bits [OUT_WIDTH-1-k*BUS_WIDTH -: BUS_WIDTH].
- Undefined: LSB-first order as in Behaviour. All other behaviour is identical.

Test Plan:
- Defaults, out_ready=1; pulses with sync_bus=01,10,11,00 on four non-adjacent cycles -> out_valid=1 for one cycle after the 4th capture edge, out_data=8'h39, chunk_cnt returns to 0, overflow=0.
- out_ready=0; word 8'h39 completes, then four more chunks 11,11,11,11 -> chunk_cnt=4 (HOLD). A 9th pulse -> overflow=1. Raise out_ready -> 8'h39 accepted, then 8'hFF presented with no bubble.
- Two chunks (10,01) then flush=1 for one cycle -> chunk_cnt=0. Next four chunks 00,00,00,11 -> out_data=8'hC0.
- Last chunk arrives on the same edge as out_valid & out_ready for the previous word -> out_valid stays 1 and out_data switches to the new word on that edge.
- RST pulsed high asynchronously after three chunks -> all outputs 0 immediately. After release, a full 4-chunk sequence produces the correct word.
- With SYN_PACKER_MSB_FIRST_EN defined, chunks 01,10,11,00 -> out_data=8'h6C.

Source files
------------

// File: rtl/syn_bus_packer.sv
// syn_bus_packer: packs NUM_CHUNKS synchronized chunks into one word, valid/ready out.
// Optional: define SYN_PACKER_MSB_FIRST_EN to place the first chunk at the top bits.
module syn_bus_packer #(
  parameter int BUS_WIDTH  = 2,
  parameter int NUM_CHUNKS = 4,
  parameter int OUT_WIDTH  = BUS_WIDTH * NUM_CHUNKS
) (
  input  logic                            CLK,
  input  logic                            RST,
  input  logic [BUS_WIDTH-1:0]            sync_bus,
  input  logic                            enable_pulse,
  input  logic                            flush,
  input  logic                            out_ready,
  output logic [OUT_WIDTH-1:0]            out_data,
  output logic                            out_valid,
  output logic                            overflow,
  output logic [$clog2(NUM_CHUNKS):0]     chunk_cnt
);

  localparam int CW = $clog2(NUM_CHUNKS) + 1;
  localparam logic [CW-1:0] LAST = CW'(NUM_CHUNKS - 1);
  localparam logic [CW-1:0] FULL = CW'(NUM_CHUNKS);

  typedef enum logic {FILL, HOLD} state_e;

  state_e               state_q, state_d;
  logic [OUT_WIDTH-1:0] buf_q, buf_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [OUT_WIDTH-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ovf_q, ovf_d;
  logic [OUT_WIDTH-1:0] word;
  logic                 drain;

  // Bit offset of chunk k inside the packed word.
  function automatic int pos(input int k);
`ifdef SYN_PACKER_MSB_FIRST_EN
    return OUT_WIDTH - (k + 1) * BUS_WIDTH;
`else
    return k * BUS_WIDTH;
`endif
  endfunction

  // Next-state: chunk insertion, word hand-off, hold slot and overflow.
  always_comb begin
    state_d = state_q;
    buf_d   = buf_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = valid_q;
    ovf_d   = ovf_q;
    word    = buf_q;
    drain   = valid_q & out_ready;
    for (int k = 0; k < NUM_CHUNKS; k++) begin
      if (cnt_q == CW'(k)) word[pos(k) +: BUS_WIDTH] = sync_bus;
    end
    if (drain) valid_d = 1'b0;
    case (state_q)
      FILL: begin
        if (flush) begin
          cnt_d = '0;
          buf_d = '0;
        end else if (enable_pulse) begin
          if (cnt_q == LAST) begin
            if (!valid_q || drain) begin
              data_d  = word;
              valid_d = 1'b1;
              cnt_d   = '0;
              buf_d   = '0;
            end else begin
              buf_d   = word;
              cnt_d   = FULL;
              state_d = HOLD;
            end
          end else begin
            buf_d = word;
            cnt_d = cnt_q + CW'(1);
          end
        end
      end
      HOLD: begin
        if (drain) begin
          data_d  = buf_q;
          valid_d = 1'b1;
          cnt_d   = '0;
          buf_d   = '0;
          state_d = FILL;
        end
        if (enable_pulse) ovf_d = 1'b1;
      end
      default: state_d = FILL;
    endcase
  end

  // State and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q <= FILL;
      buf_q   <= '0;
      cnt_q   <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      buf_q   <= buf_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_data  = data_q;
  assign out_valid = valid_q;
  assign overflow  = ovf_q;
  assign chunk_cnt = cnt_q;

endmodule

// File: tb/tb_syn_bus_packer.sv
// tb_syn_bus_packer: scoreboard bench with a queue-based packing model.
// Word constants follow SYN_PACKER_MSB_FIRST_EN when it is defined.
module tb_syn_bus_packer;

  localparam int BW = 2;
  localparam int N  = 4;
  localparam int OW = BW * N;

`ifdef SYN_PACKER_MSB_FIRST_EN
  localparam logic [OW-1:0] W1 = 8'h6C;
  localparam logic [OW-1:0] W3 = 8'h03;
  localparam logic [OW-1:0] W5 = 8'h9D;
`else
  localparam logic [OW-1:0] W1 = 8'h39;
  localparam logic [OW-1:0] W3 = 8'hC0;
  localparam logic [OW-1:0] W5 = 8'h76;
`endif

  logic          CLK = 1'b0;
  logic          RST;
  logic [BW-1:0] sync_bus;
  logic          enable_pulse;
  logic          flush;
  logic          out_ready;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          overflow;
  logic [2:0]    chunk_cnt;

  syn_bus_packer dut (
    .CLK          (CLK),
    .RST          (RST),
    .sync_bus     (sync_bus),
    .enable_pulse (enable_pulse),
    .flush        (flush),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_valid    (out_valid),
    .overflow     (overflow),
    .chunk_cnt    (chunk_cnt)
  );

  always #5 CLK = ~CLK;

  int            tests = 0;
  int            fails = 0;
  logic [BW-1:0] part[$];
  logic [OW-1:0] exp_q[$];
  int            nw = 0;
  bit            m_ovf = 0;
  logic [OW-1:0] last_acc = '0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [OW-1:0] pack();
    logic [OW-1:0] w = '0;
    for (int k = 0; k < N; k++) begin
`ifdef SYN_PACKER_MSB_FIRST_EN
      w[OW-1-k*BW -: BW] = part[k];
`else
      w[k*BW +: BW] = part[k];
`endif
    end
    return w;
  endfunction

  // Check status, drive inputs for the next edge, advance the model.
  task automatic cyc(input bit en, input logic [BW-1:0] b,
                     input bit fl, input bit rd);
    bit held;
    @(posedge CLK);
    #1;
    chk("out_valid", 32'(out_valid), 32'(nw > 0));
    chk("chunk_cnt", 32'(chunk_cnt), (nw == 2) ? N : part.size());
    chk("overflow", 32'(overflow), 32'(m_ovf));
    enable_pulse = en;
    sync_bus     = b;
    flush        = fl;
    out_ready    = rd;
    held = (nw == 2);
    if (nw > 0 && rd) nw--;
    if (held) begin
      if (en) m_ovf = 1;
    end else if (fl) begin
      part.delete();
    end else if (en) begin
      part.push_back(b);
      if (part.size() == N) begin
        exp_q.push_back(pack());
        nw++;
        part.delete();
      end
    end
  endtask

  task automatic idle(input bit rd, input int n);
    for (int i = 0; i < n; i++) cyc(0, '0, 0, rd);
  endtask

  // Monitor: every accepted word is checked against the scoreboard.
  always @(negedge CLK) begin
    if (!RST && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL out_data: got %0h expected no word", out_data);
      end else begin
        chk("out_data", 32'(out_data), 32'(exp_q.pop_front()));
        last_acc = out_data;
      end
    end
  end

  initial begin
    RST = 1'b1;
    sync_bus = '0;
    enable_pulse = 0;
    flush = 0;
    out_ready = 0;
    repeat (2) @(negedge CLK);
    chk("rst_data", 32'(out_data), 0);
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ovf", 32'(overflow), 0);
    chk("rst_cnt", 32'(chunk_cnt), 0);
    RST = 1'b0;

    cyc(1, 2'b01, 0, 1); idle(1, 1);
    cyc(1, 2'b10, 0, 1); idle(1, 1);
    cyc(1, 2'b11, 0, 1); idle(1, 1);
    cyc(1, 2'b00, 0, 1); idle(1, 2);
    chk("word_basic", 32'(last_acc), 32'(W1));

    cyc(1, 2'b10, 0, 1);
    cyc(1, 2'b01, 0, 1);
    cyc(0, 2'b00, 1, 1);
    cyc(1, 2'b00, 0, 1);
    cyc(1, 2'b00, 0, 1);
    cyc(1, 2'b00, 0, 1);
    cyc(1, 2'b11, 0, 1);
    idle(1, 2);
    chk("word_flush", 32'(last_acc), 32'(W3));

    cyc(1, 2'b01, 0, 0); cyc(1, 2'b10, 0, 0);
    cyc(1, 2'b11, 0, 0); cyc(1, 2'b00, 0, 0);
    cyc(1, 2'b11, 0, 0); cyc(1, 2'b11, 0, 0);
    cyc(1, 2'b11, 0, 0); cyc(1, 2'b10, 0, 1);
    idle(1, 3);

    cyc(1, 2'b01, 0, 0); cyc(1, 2'b10, 0, 0);
    cyc(1, 2'b11, 0, 0); cyc(1, 2'b00, 0, 0);
    for (int i = 0; i < N; i++) cyc(1, 2'b11, 0, 0);
    idle(0, 1);
    chk("hold_cnt", 32'(chunk_cnt), N);
    cyc(1, 2'b01, 0, 0);
    idle(0, 1);
    chk("ovf_set", 32'(overflow), 1);
    idle(1, 3);
    chk("word_held", 32'(last_acc), 32'hFF);

    cyc(1, 2'b01, 0, 1); cyc(1, 2'b01, 0, 1); cyc(1, 2'b01, 0, 1);
    @(posedge CLK);
    #3;
    RST = 1'b1;
    enable_pulse = 0;
    #1;
    chk("arst_data", 32'(out_data), 0);
    chk("arst_valid", 32'(out_valid), 0);
    chk("arst_ovf", 32'(overflow), 0);
    chk("arst_cnt", 32'(chunk_cnt), 0);
    part.delete();
    exp_q.delete();
    nw = 0;
    m_ovf = 0;
    @(negedge CLK);
    RST = 1'b0;
    cyc(1, 2'b10, 0, 1); cyc(1, 2'b01, 0, 1);
    cyc(1, 2'b11, 0, 1); cyc(1, 2'b01, 0, 1);
    idle(1, 2);
    chk("word_after_rst", 32'(last_acc), 32'(W5));

    for (int i = 0; i < 800; i++) begin
      cyc(bit'($urandom_range(0, 1)), BW'($urandom),
          ($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0));
    end
    idle(1, 6);
    chk("drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
